neuron_accumulator: RTL and testbench
=====================================

# neuron_accumulator

Downstream consumer of `DotProduct`. Each `DotProduct` result is one 10-pixel/10-weight partial product. This block accumulates `CHUNKS` consecutive partial products into one neuron sum, adds a bias, then saturates and optionally applies ReLU. It presents the neuron activation through a valid/ready handshake to the layer output buffer.

## Interface
Parameters:
- `CHUNKS`, 79, partial products per neuron (784 pixels / 10, zero-padded)
- `ACC_W`, 33, accumulator width (26 + 7 guard bits; must be ≥ 26 + clog2(CHUNKS))
- `RELU`, 1, 1 = clamp negative results to 0

Ports:
- `clk`  in  1  clock; single clock domain
- `GlobalReset`  in  1  synchronous, active-high reset
- `in_valid`  in  1  `in_value` holds a partial product
- `in_ready`  out  1  block accepts a beat this cycle
- `in_value`  in  26  signed partial product, Q8.18 (`DotProduct` `value` format)
- `bias`  in  26  signed Q8.18; stable from first accepted beat until `out_valid`
- `out_valid`  out  1  `out_value` is valid
- `out_ready`  in  1  consumer accepts the result
- `out_value`  out  26  signed Q8.18 activation
- `out_overflow`  out  1  the reported result saturated

## Operation
- States: IDLE, ACCUM, FINISH, HOLD.
- IDLE:
  - `in_ready`=1.
  - An accepted beat (`in_valid && in_ready`) loads `acc <= sext(in_value)` and sets `cnt <= 1`.
  - Next state: ACCUM, or FINISH if `CHUNKS==1`.
- ACCUM:
  - `in_ready`=1.
  - Each accepted beat does `acc <= acc + sext(in_value)` and `cnt++`.
  - The beat that makes `cnt==CHUNKS` moves to FINISH.
  - Cycles without `in_valid` hold state; no timeout.
- FINISH (one cycle):
  - `in_ready`=0.
  - `sum = acc + sext(bias)`.
  - Saturate to 26 bits: above 2^25−1 → 0x1FFFFFF; below −2^25 → 0x2000000; `ovf`=1 on either.
  - If `RELU`, a negative saturated value becomes 0; `ovf` is kept.
  - Register `out_value`/`out_overflow`, then go to HOLD.
- HOLD:
  - `out_valid`=1, `in_ready`=0; `in_valid` is ignored.
  - On `out_valid && out_ready`, go to IDLE.
  - `out_value` and `out_overflow` stay stable until that handshake.
- Arithmetic:
  - Two's complement throughout, with no rounding.
  - Inputs are sign-extended to `ACC_W`.
  - The guard bits make accumulator overflow impossible for legal `ACC_W`.

## Timing
- Reset values: state=IDLE, `acc`=0, `cnt`=0, `in_ready`=1, `out_valid`=0, `out_value`=0, `out_overflow`=0. `in_ready` is combinational from state, so it reads 1 in the first cycle after reset.
- Reset has priority over every event. Asserting it mid-ACCUM or mid-HOLD discards the partial sum or pending result with no output pulse.
- Latency: if the last beat is accepted at edge t, then FINISH runs at t..t+1 and `out_valid` rises after edge t+1.
- Throughput: one neuron per CHUNKS+2 cycles when `out_ready`=1.
- Back-to-back: the first beat of the next neuron can be accepted the cycle after the output handshake.
- Upstream must stall `DotProduct` when `in_ready`=0. A beat offered while `in_ready`=0 is not consumed.

## Structure
- `neuron_pkg` holds:
  - `VALUE_W`=26 and `FRAC_W`=18
  - the state enum
  - a `sat26` function (ACC_W → 26 with overflow flag)
- Sub-module `sat_relu` is combinational: sum in, 26-bit value and `ovf` out, `RELU` parameter. It is used in FINISH.
- Counter width is clog2(CHUNKS+1).

## Test plan
- Nominal, `CHUNKS`=4, `RELU`=1: inputs 1.0, 2.0, −0.5, 0.25 (0x0040000, 0x0080000, 0x3FE0000, 0x0010000), `bias`=0.25, `out_ready`=1 → `out_value`=0x00C0000 (3.0), `out_overflow`=0, `out_valid` 2 cycles after the last beat.
- Overflow, default `CHUNKS`=79: each beat is 90.0 (0x1680000, i.e. 10 pixels 0..9 × weights 2.0), `bias`=0 → `out_value`=0x1FFFFFF, `out_overflow`=1.
- ReLU: `CHUNKS`=4, four beats of −1.0, `bias`=0 → `out_value`=0, `out_overflow`=0. The same case with `RELU`=0 → 0x3F00000.
- Backpressure: `out_ready`=0 for 5 cycles after `out_valid` while `in_valid`=1 → `out_valid`, `out_value` and `in_ready`=0 all held, and no beats consumed. Then `out_ready`=1 → one handshake, and the next beat is accepted the following cycle.
- Reset mid-operation: `CHUNKS`=4, after 2 beats of 5.0 assert `GlobalReset` for 1 cycle, then send 4 beats of 1.0 with `bias`=0 → `out_value`=0x0100000 (4.0).
- Gapped input: `CHUNKS`=4, random `in_valid` gaps of 0–3 cycles → the same result as the nominal case.

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared types and helpers for the neuron accumulator: Q8.18 widths, FSM states
// and the 26-bit saturation function.
package neuron_pkg;

  localparam int VALUE_W  = 26;
  localparam int FRAC_W   = 18;
  localparam int SAT_IN_W = 64;

  typedef enum logic [1:0] {IDLE, ACCUM, FINISH, HOLD} state_t;

  typedef struct packed {
    logic [VALUE_W-1:0] value;
    logic               ovf;
  } sat_t;

  // Callers sign-extend their sum to SAT_IN_W so one function serves any ACC_W.
  function automatic sat_t sat26(input logic signed [SAT_IN_W-1:0] sum);
    sat_t r;
    if (sum > 64'sd33554431) begin
      r.value = 26'h1FFFFFF;
      r.ovf   = 1'b1;
    end else if (sum < -64'sd33554432) begin
      r.value = 26'h2000000;
      r.ovf   = 1'b1;
    end else begin
      r.value = sum[VALUE_W-1:0];
      r.ovf   = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/neuron_accumulator_if.sv
// Partial-product input and activation output handshakes of the neuron accumulator.
interface neuron_accumulator_if;
  import neuron_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [VALUE_W-1:0] in_value;
  logic [VALUE_W-1:0] bias;
  logic               out_valid;
  logic               out_ready;
  logic [VALUE_W-1:0] out_value;
  logic               out_overflow;

  modport master (
    output in_valid, in_value, bias, out_ready,
    input  in_ready, out_valid, out_value, out_overflow
  );

  modport slave (
    input  in_valid, in_value, bias, out_ready,
    output in_ready, out_valid, out_value, out_overflow
  );

endinterface

// File: rtl/neuron_accumulator_sat_relu.sv
// Combinational saturation of the biased neuron sum to Q8.18, with optional ReLU.
module sat_relu
  import neuron_pkg::*;
#(
  parameter int ACC_W = 33,
  parameter int RELU  = 1
) (
  input  logic signed [ACC_W-1:0] sum,
  output logic [VALUE_W-1:0]      value,
  output logic                    ovf
);

  logic signed [SAT_IN_W-1:0] sum_wide;
  sat_t                       sat;

  assign sum_wide = {{(SAT_IN_W-ACC_W){sum[ACC_W-1]}}, sum};

  // ReLU acts after saturation, so a clamped negative overflow still reports ovf.
  always_comb begin
    sat   = sat26(sum_wide);
    value = sat.value;
    ovf   = sat.ovf;
    if (RELU != 0 && sat.value[VALUE_W-1]) begin
      value = '0;
    end
  end

endmodule

// File: rtl/neuron_accumulator.sv
// Accumulates CHUNKS DotProduct partial products, adds bias, saturates/ReLUs,
// and offers the activation on a valid/ready handshake.
module neuron_accumulator
  import neuron_pkg::*;
#(
  parameter int CHUNKS = 79,
  parameter int ACC_W  = 33,
  parameter int RELU   = 1
) (
  input  logic                  clk,
  input  logic                  GlobalReset,
  neuron_accumulator_if.slave   bus
);

  localparam int CNT_W = $clog2(CHUNKS + 1);

  state_t                   state, next_state;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  in_sext;
  logic signed [ACC_W-1:0]  bias_sext;
  logic signed [ACC_W-1:0]  sum;
  logic [CNT_W-1:0]         cnt;
  logic                     accept;
  logic                     last_beat;
  logic [VALUE_W-1:0]       sat_value;
  logic                     sat_ovf;
  logic [VALUE_W-1:0]       out_value_q;
  logic                     out_overflow_q;

  assign in_sext   = {{(ACC_W-VALUE_W){bus.in_value[VALUE_W-1]}}, bus.in_value};
  assign bias_sext = {{(ACC_W-VALUE_W){bus.bias[VALUE_W-1]}}, bus.bias};
  assign sum       = acc + bias_sext;
  assign accept    = bus.in_valid && bus.in_ready;
  assign last_beat = (state == IDLE  && CHUNKS == 1) ||
                     (state == ACCUM && cnt == CNT_W'(CHUNKS - 1));

  sat_relu #(.ACC_W(ACC_W), .RELU(RELU)) u_sat_relu (
    .sum   (sum),
    .value (sat_value),
    .ovf   (sat_ovf)
  );

  always_ff @(posedge clk) begin
    if (GlobalReset) state <= IDLE;
    else             state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE, ACCUM: if (accept) next_state = last_beat ? FINISH : ACCUM;
      FINISH:      next_state = HOLD;
      HOLD:        if (bus.out_ready) next_state = IDLE;
      default:     next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready     = (state == IDLE) || (state == ACCUM);
    bus.out_valid    = (state == HOLD);
    bus.out_value    = out_value_q;
    bus.out_overflow = out_overflow_q;
  end

  // The first beat of a neuron overwrites acc, so no clear is needed between neurons.
  always_ff @(posedge clk) begin
    if (GlobalReset) begin
      acc            <= '0;
      cnt            <= '0;
      out_value_q    <= '0;
      out_overflow_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          acc <= in_sext;
          cnt <= CNT_W'(1);
        end
        ACCUM: if (accept) begin
          acc <= acc + in_sext;
          cnt <= cnt + 1'b1;
        end
        FINISH: begin
          out_value_q    <= sat_value;
          out_overflow_q <= sat_ovf;
          cnt            <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_accumulator.sv
// Directed bench: three instances (4 chunks ReLU, 79 chunks ReLU, 4 chunks linear)
// exercised through per-scenario tasks with hand-computed Q8.18 results.
module tb_neuron_accumulator;

  logic clk = 1'b0;
  logic GlobalReset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  localparam logic [25:0] ONE      = 26'h0040000;
  localparam logic [25:0] TWO      = 26'h0080000;
  localparam logic [25:0] NEG_HALF = 26'h3FE0000;
  localparam logic [25:0] QUARTER  = 26'h0010000;
  localparam logic [25:0] NEG_ONE  = 26'h3FC0000;
  localparam logic [25:0] FIVE     = 26'h0140000;
  localparam logic [25:0] NINETY   = 26'h1680000;

  always #5 clk = ~clk;

  neuron_accumulator_if bus_a ();
  neuron_accumulator_if bus_b ();
  neuron_accumulator_if bus_c ();

  neuron_accumulator #(.CHUNKS(4), .ACC_W(33), .RELU(1)) dut_a (
    .clk(clk), .GlobalReset(GlobalReset), .bus(bus_a));
  neuron_accumulator #(.CHUNKS(79), .ACC_W(33), .RELU(1)) dut_b (
    .clk(clk), .GlobalReset(GlobalReset), .bus(bus_b));
  neuron_accumulator #(.CHUNKS(4), .ACC_W(33), .RELU(0)) dut_c (
    .clk(clk), .GlobalReset(GlobalReset), .bus(bus_c));

  task automatic beat_a(input logic [25:0] v, input int gap);
    repeat (gap) @(negedge clk);
    @(negedge clk);
    bus_a.in_valid = 1'b1;
    bus_a.in_value = v;
    @(posedge clk);
    #1 bus_a.in_valid = 1'b0;
  endtask

  // Counts negedges from the last accepted beat until out_valid; expected 2.
  task automatic wait_out_a(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus_a.out_valid && n < 20);
    total++;
    if (n !== 2) begin
      bad++;
      $display("[TB] FAIL %s latency: got %0d cycles, expected 2", name, n);
    end
  endtask

  task automatic check_a(input string name, input logic [25:0] val, input logic ovf);
    total++;
    if (bus_a.out_value !== val) begin
      bad++;
      $display("[TB] FAIL %s value: got %h, expected %h", name, bus_a.out_value, val);
    end
    total++;
    if (bus_a.out_overflow !== ovf) begin
      bad++;
      $display("[TB] FAIL %s overflow: got %b, expected %b", name, bus_a.out_overflow, ovf);
    end
  endtask

  task automatic test_reset;
    GlobalReset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    GlobalReset = 1'b0;
    #1;
    total++;
    if ({bus_a.in_ready, bus_a.out_valid, bus_a.out_value, bus_a.out_overflow} !== {1'b1, 1'b0, 26'h0, 1'b0}) begin
      bad++;
      $display("[TB] FAIL reset_a: got rdy=%b vld=%b val=%h ovf=%b, expected 1 0 0 0",
               bus_a.in_ready, bus_a.out_valid, bus_a.out_value, bus_a.out_overflow);
    end
    total++;
    if ({bus_b.in_ready, bus_b.out_valid, bus_b.out_value, bus_b.out_overflow} !== {1'b1, 1'b0, 26'h0, 1'b0}) begin
      bad++;
      $display("[TB] FAIL reset_b: got rdy=%b vld=%b val=%h ovf=%b, expected 1 0 0 0",
               bus_b.in_ready, bus_b.out_valid, bus_b.out_value, bus_b.out_overflow);
    end
    total++;
    if ({bus_c.in_ready, bus_c.out_valid} !== 2'b10) begin
      bad++;
      $display("[TB] FAIL reset_c: got rdy=%b vld=%b, expected 1 0", bus_c.in_ready, bus_c.out_valid);
    end
  endtask

  // 1.0 + 2.0 - 0.5 + 0.25 + bias 0.25 = 3.0
  task automatic test_nominal(input string name, input int max_gap);
    bus_a.bias = QUARTER;
    beat_a(ONE,      $urandom_range(0, max_gap));
    beat_a(TWO,      $urandom_range(0, max_gap));
    beat_a(NEG_HALF, $urandom_range(0, max_gap));
    beat_a(QUARTER,  $urandom_range(0, max_gap));
    wait_out_a(name);
    check_a(name, 26'h00C0000, 1'b0);
    @(negedge clk);
    total++;
    if (bus_a.out_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL %s handshake: out_valid got %b, expected 0", name, bus_a.out_valid);
    end
  endtask

  // 79 x 90.0 = 7110.0 exceeds Q8.18 range.
  task automatic test_overflow;
    int n = 0;
    bus_b.bias = 26'h0;
    @(negedge clk);
    bus_b.in_valid = 1'b1;
    bus_b.in_value = NINETY;
    repeat (79) @(posedge clk);
    #1 bus_b.in_valid = 1'b0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus_b.out_valid && n < 20);
    total++;
    if (n !== 2) begin
      bad++;
      $display("[TB] FAIL overflow latency: got %0d cycles, expected 2", n);
    end
    total++;
    if (bus_b.out_value !== 26'h1FFFFFF || bus_b.out_overflow !== 1'b1) begin
      bad++;
      $display("[TB] FAIL overflow result: got %h ovf=%b, expected 1ffffff ovf=1",
               bus_b.out_value, bus_b.out_overflow);
    end
    @(negedge clk);
  endtask

  // Four beats of -1.0: ReLU instance yields 0, linear instance yields -4.0.
  task automatic test_relu;
    int n = 0;
    bus_a.bias = 26'h0;
    bus_c.bias = 26'h0;
    @(negedge clk);
    bus_a.in_valid = 1'b1;  bus_a.in_value = NEG_ONE;
    bus_c.in_valid = 1'b1;  bus_c.in_value = NEG_ONE;
    repeat (4) @(posedge clk);
    #1;
    bus_a.in_valid = 1'b0;
    bus_c.in_valid = 1'b0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus_c.out_valid && n < 20);
    total++;
    if (n !== 2 || bus_a.out_valid !== 1'b1) begin
      bad++;
      $display("[TB] FAIL relu latency: got %0d cycles a_vld=%b, expected 2 and 1", n, bus_a.out_valid);
    end
    check_a("relu_on", 26'h0, 1'b0);
    total++;
    if (bus_c.out_value !== 26'h3F00000 || bus_c.out_overflow !== 1'b0) begin
      bad++;
      $display("[TB] FAIL relu_off: got %h ovf=%b, expected 3f00000 ovf=0",
               bus_c.out_value, bus_c.out_overflow);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    bus_a.bias = QUARTER;
    bus_a.out_ready = 1'b0;
    beat_a(ONE, 0);
    beat_a(TWO, 0);
    beat_a(NEG_HALF, 0);
    beat_a(QUARTER, 0);
    wait_out_a("backpressure");
    bus_a.in_valid = 1'b1;
    bus_a.in_value = ONE;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (bus_a.out_valid !== 1'b1 || bus_a.in_ready !== 1'b0 || bus_a.out_value !== 26'h00C0000) begin
        bad++;
        $display("[TB] FAIL backpressure hold %0d: got vld=%b rdy=%b val=%h, expected 1 0 00c0000",
                 i, bus_a.out_valid, bus_a.in_ready, bus_a.out_value);
      end
      @(negedge clk);
    end
    bus_a.out_ready = 1'b1;
    @(negedge clk);
    total++;
    if (bus_a.out_valid !== 1'b0 || bus_a.in_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL backpressure release: got vld=%b rdy=%b, expected 0 1",
               bus_a.out_valid, bus_a.in_ready);
    end
    @(posedge clk);
    #1 bus_a.in_valid = 1'b0;
    beat_a(TWO, 0);
    beat_a(NEG_HALF, 0);
    beat_a(QUARTER, 0);
    wait_out_a("backpressure_next");
    check_a("backpressure_next", 26'h00C0000, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    bus_a.bias = 26'h0;
    beat_a(FIVE, 0);
    beat_a(FIVE, 0);
    @(negedge clk);
    GlobalReset = 1'b1;
    @(negedge clk);
    GlobalReset = 1'b0;
    total++;
    if (bus_a.out_valid !== 1'b0 || bus_a.in_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reset_mid state: got vld=%b rdy=%b, expected 0 1",
               bus_a.out_valid, bus_a.in_ready);
    end
    for (int i = 0; i < 4; i++) beat_a(ONE, 0);
    wait_out_a("reset_mid");
    check_a("reset_mid", 26'h0100000, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    bus_a.in_valid = 1'b0; bus_a.in_value = '0; bus_a.bias = '0; bus_a.out_ready = 1'b1;
    bus_b.in_valid = 1'b0; bus_b.in_value = '0; bus_b.bias = '0; bus_b.out_ready = 1'b1;
    bus_c.in_valid = 1'b0; bus_c.in_value = '0; bus_c.bias = '0; bus_c.out_ready = 1'b1;
    test_reset();
    test_nominal("nominal", 0);
    test_overflow();
    test_relu();
    test_backpressure();
    test_reset_mid();
    test_nominal("gapped", 3);
    test_nominal("gapped2", 3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
